// File: rtl/idelay_pkg.sv
// rtl/idelay_pkg.sv - shared types and constants for the IDELAY tap sequencer
package idelay_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RDY,
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DWELL
    } idelay_state_t;

    localparam int   IDELAY_TAPS = 32;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/idelay_rdy_sync.sv
// rtl/idelay_rdy_sync.sv - two-flop synchroniser for IDELAYCTRL RDY
module idelay_rdy_sync
    import idelay_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // two-stage capture of the asynchronous RDY level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/idelay_tap_sequencer.sv
// rtl/idelay_tap_sequencer.sv - per-channel IDELAYE2 tap loader with calibration sweep
module idelay_tap_sequencer
    import idelay_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int TAP_W         = 5,
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_TAP       = 0,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      idelayctrl_rdy,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_mode,
    input  logic                      cfg_bcast,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [TAP_W-1:0]          cfg_tap,
    input  logic [TAP_W-1:0]          cfg_tap_end,
    input  logic [DWELL_W-1:0]        cfg_dwell,
    input  logic                      abort,
    output logic [NUM_CH*TAP_W-1:0]   tap_value,
    output logic [NUM_CH-1:0]         tap_ld,
    output logic                      sample_en,
    output logic [TAP_W-1:0]          step_tap,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      rdy_lost
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;

    idelay_state_t      r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [TAP_W-1:0]   r_taps [NUM_CH];
    logic [NUM_CH-1:0]  r_ld;
    logic [TAP_W-1:0]   r_cur;
    logic [TAP_W-1:0]   r_end;
    logic [DWELL_W-1:0] r_dwell;
    logic [CH_W-1:0]    r_ch;
    logic               r_mode, r_up;
    logic               r_done, r_err, r_lost, r_busy;

    logic               w_rdy_s;
    logic               w_bad, w_accept, w_reject, w_done, w_lost;
    logic               w_load_go;
    logic [TAP_W-1:0]   w_load_tap;
    logic [NUM_CH-1:0]  w_load_mask;

    idelay_rdy_sync u_rdy_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (idelayctrl_rdy),
        .o_sync  (w_rdy_s)
    );

    // sweeps never broadcast, and a non-broadcast channel must exist
    assign w_bad = (!cfg_bcast && (32'(cfg_ch) >= NUM_CH)) ||
                   (cfg_mode == MODE_SWEEP && cfg_bcast);

    // next state, counter and load request; RDY loss outranks abort
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_done      = 1'b0;
        w_lost      = 1'b0;
        w_load_go   = 1'b0;
        w_load_tap  = r_cur;
        w_load_mask = '0;
        if (r_state != ST_WAIT_RDY && !w_rdy_s) begin
            w_next = ST_WAIT_RDY;
            w_lost = 1'b1;
        end else if (r_state != ST_WAIT_RDY && r_state != ST_IDLE && abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_WAIT_RDY: begin
                    if (w_rdy_s) w_next = ST_IDLE;
                end
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_bad) begin
                            w_reject = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_next      = ST_LOAD;
                            w_load_go   = 1'b1;
                            w_load_tap  = cfg_tap;
                            w_load_mask = cfg_bcast ? '1 : (NUM_CH'(1) << cfg_ch);
                        end
                    end
                end
                ST_LOAD: begin
                    w_next     = ST_SETTLE;
                    w_cnt_next = CNT_W'(SETTLE_CYCLES - 1);
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end else if (r_mode == MODE_DIRECT) begin
                        w_done = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_next     = ST_DWELL;
                        w_cnt_next = (r_dwell == '0) ? '0 : CNT_W'(r_dwell) - CNT_W'(1);
                    end
                end
                ST_DWELL: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end else if (r_cur == r_end) begin
                        w_done = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_next      = ST_LOAD;
                        w_load_go   = 1'b1;
                        w_load_tap  = r_up ? r_cur + TAP_W'(1) : r_cur - TAP_W'(1);
                        w_load_mask = NUM_CH'(1) << r_ch;
                    end
                end
                default: w_next = ST_WAIT_RDY;
            endcase
        end
    end

    // state, command latch, registered tap/LD so both reach the primitive together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_RDY;
            r_cnt   <= '0;
            r_ld    <= '0;
            r_cur   <= '0;
            r_end   <= '0;
            r_dwell <= '0;
            r_ch    <= '0;
            r_mode  <= 1'b0;
            r_up    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_lost  <= 1'b0;
            r_busy  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_taps[k] <= TAP_W'(RST_TAP);
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ld    <= w_load_go ? w_load_mask : '0;
            r_done  <= w_done;
            r_err   <= w_reject;
            r_busy  <= (w_next != ST_IDLE);
            if (w_lost)        r_lost <= 1'b1;
            else if (w_accept) r_lost <= 1'b0;
            if (w_load_go) begin
                r_cur <= w_load_tap;
                for (int k = 0; k < NUM_CH; k++)
                    if (w_load_mask[k]) r_taps[k] <= w_load_tap;
            end
            if (w_accept) begin
                r_mode  <= cfg_mode;
                r_ch    <= cfg_ch;
                r_end   <= cfg_tap_end;
                r_dwell <= cfg_dwell;
                r_up    <= (cfg_tap < cfg_tap_end);
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
        assign tap_value[k*TAP_W +: TAP_W] = r_taps[k];
    end

    assign tap_ld    = r_ld;
    assign cfg_ready = (r_state == ST_IDLE) && w_rdy_s;
    assign sample_en = (r_state == ST_DWELL);
    assign step_tap  = r_cur;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdy_lost  = r_lost;

endmodule

// File: tb/tb_idelay_tap_sequencer.sv
// tb/tb_idelay_tap_sequencer.sv - directed self-checking bench for idelay_tap_sequencer
module tb_idelay_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst, idelayctrl_rdy, cfg_valid, cfg_mode, cfg_bcast, abort;
    logic [1:0]  cfg_ch;
    logic [4:0]  cfg_tap, cfg_tap_end;
    logic [15:0] cfg_dwell;

    logic        cfg_ready, sample_en, busy, done, err, rdy_lost;
    logic [19:0] tap_value;
    logic [3:0]  tap_ld;
    logic [4:0]  step_tap;

    logic        cfg_ready3, sample_en3, busy3, done3, err3, rdy_lost3;
    logic [14:0] tap_value3;
    logic [2:0]  tap_ld3;
    logic [4:0]  step_tap3;

    idelay_tap_sequencer dut (
        .clk(clk), .rst(rst), .idelayctrl_rdy(idelayctrl_rdy),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_bcast(cfg_bcast), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
        .cfg_tap_end(cfg_tap_end), .cfg_dwell(cfg_dwell), .abort(abort),
        .tap_value(tap_value), .tap_ld(tap_ld), .sample_en(sample_en),
        .step_tap(step_tap), .busy(busy), .done(done), .err(err),
        .rdy_lost(rdy_lost)
    );

    idelay_tap_sequencer #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .idelayctrl_rdy(idelayctrl_rdy),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3), .cfg_mode(cfg_mode),
        .cfg_bcast(cfg_bcast), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
        .cfg_tap_end(cfg_tap_end), .cfg_dwell(cfg_dwell), .abort(abort),
        .tap_value(tap_value3), .tap_ld(tap_ld3), .sample_en(sample_en3),
        .step_tap(step_tap3), .busy(busy3), .done(done3), .err(err3),
        .rdy_lost(rdy_lost3)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int         m_ld, m_done, m_lat;
    logic [3:0] m_mask;
    int         m_steps [16];
    int         m_se    [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] tapv(input int k);
        return tap_value[k*5 +: 5];
    endfunction

    task automatic issue(input logic m, input logic b, input logic [1:0] ch,
                         input logic [4:0] t, input logic [4:0] te, input logic [15:0] d);
        cfg_mode = m; cfg_bcast = b; cfg_ch = ch;
        cfg_tap = t; cfg_tap_end = te; cfg_dwell = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // cycle i=1 is the cycle right after the accepting edge
    task automatic watch(input int maxc, input bit stop_on_done);
        m_ld = 0; m_done = 0; m_lat = 0; m_mask = '0;
        for (int j = 0; j < 16; j++) begin
            m_steps[j] = -1;
            m_se[j]    = 0;
        end
        for (int i = 1; i <= maxc; i++) begin
            if (tap_ld != 0) begin
                if (m_ld < 16) m_steps[m_ld] = int'(step_tap);
                m_ld++;
                m_mask |= tap_ld;
            end
            if (sample_en && m_ld > 0 && m_ld <= 16) m_se[m_ld-1]++;
            if (done) begin
                m_done++;
                if (m_lat == 0) m_lat = i;
            end
            if (stop_on_done && done) break;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; idelayctrl_rdy = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
        cfg_mode = 1'b0; cfg_bcast = 1'b0; cfg_ch = '0;
        cfg_tap = '0; cfg_tap_end = '0; cfg_dwell = '0;
        repeat (3) tick();
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_taps", 32'(tap_value), 0);
        check("rst_ld", 32'(tap_ld), 0);
        check("rst_flags", 32'({done, err, rdy_lost, sample_en}), 0);
        rst = 1'b0;

        // RDY comes up at cycle 10
        for (int c = 1; c <= 10; c++) tick();
        check("no_rdy_ready", 32'(cfg_ready), 0);
        idelayctrl_rdy = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cfg_ready) begin
                lat = c;
                break;
            end
        end
        check("rdy_latency_ok", 32'(lat == 2 || lat == 3), 1);
        check("idle_taps", 32'(tap_value), 0);

        // direct load ch2 = 17
        issue(1'b0, 1'b0, 2'd2, 5'd17, 5'd0, 16'd0);
        check("dir_ld", 32'(tap_ld), 32'h4);
        check("dir_val", 32'(tapv(2)), 17);
        check("dir_busy", 32'(busy), 1);
        watch(20, 1'b1);
        check("dir_lat", 32'(m_lat), 6);
        check("dir_ldcnt", 32'(m_ld), 1);
        tick();
        check("dir_done_pulse", 32'(done), 0);
        check("dir_idle", 32'(busy), 0);

        // broadcast 9
        issue(1'b0, 1'b1, 2'd0, 5'd9, 5'd0, 16'd0);
        check("bc_ld", 32'(tap_ld), 32'hF);
        watch(20, 1'b1);
        check("bc_done", 32'(m_done), 1);
        for (int k = 0; k < 4; k++) check($sformatf("bc_val%0d", k), 32'(tapv(k)), 9);

        // ascending sweep ch1 3..6, dwell 5
        issue(1'b1, 1'b0, 2'd1, 5'd3, 5'd6, 16'd5);
        watch(100, 1'b1);
        check("up_ldcnt", 32'(m_ld), 4);
        check("up_mask", 32'(m_mask), 32'h2);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("up_step%0d", j), 32'(m_steps[j]), 32'(3 + j));
            check($sformatf("up_se%0d", j), 32'(m_se[j]), 5);
        end
        check("up_done", 32'(m_done), 1);
        check("up_lat", 32'(m_lat), 41);
        check("up_final", 32'(tapv(1)), 6);

        // descending sweep ch3 31..29, dwell 0
        issue(1'b1, 1'b0, 2'd3, 5'd31, 5'd29, 16'd0);
        watch(100, 1'b1);
        check("dn_ldcnt", 32'(m_ld), 3);
        check("dn_mask", 32'(m_mask), 32'h8);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("dn_step%0d", j), 32'(m_steps[j]), 32'(31 - j));
            check($sformatf("dn_se%0d", j), 32'(m_se[j]), 1);
        end
        check("dn_lat", 32'(m_lat), 19);
        check("dn_final", 32'(tapv(3)), 29);

        // broadcast sweep is rejected
        issue(1'b1, 1'b1, 2'd0, 5'd1, 5'd2, 16'd1);
        check("rej_err", 32'(err), 1);
        check("rej_ld", 32'(tap_ld), 0);
        check("rej_ready", 32'(cfg_ready), 1);
        tick();
        check("rej_err_pulse", 32'(err), 0);
        check("rej_noload", 32'(tap_ld), 0);

        // ch3 is out of range only for the 3-channel instance
        issue(1'b0, 1'b0, 2'd3, 5'd12, 5'd0, 16'd0);
        check("ch3_err3", 32'(err3), 1);
        check("ch3_ld3", 32'(tap_ld3), 0);
        check("ch3_err4", 32'(err), 0);
        check("ch3_ld4", 32'(tap_ld), 32'h8);
        watch(20, 1'b1);
        check("ch3_done", 32'(m_done), 1);
        check("ch3_val", 32'(tapv(3)), 12);

        // RDY drop mid-sweep on ch0 0..10
        issue(1'b1, 1'b0, 2'd0, 5'd0, 5'd10, 16'd5);
        repeat (14) tick();
        idelayctrl_rdy = 1'b0;
        watch(30, 1'b0);
        check("drop_done", 32'(m_done), 0);
        check("drop_ld", 32'(m_ld), 0);
        check("drop_lost", 32'(rdy_lost), 1);
        check("drop_ready", 32'(cfg_ready), 0);
        check("drop_se", 32'(sample_en), 0);
        check("drop_tap", 32'(tapv(0)), 1);
        idelayctrl_rdy = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cfg_ready) break;
        end
        check("back_ready", 32'(cfg_ready), 1);
        check("back_lost_sticky", 32'(rdy_lost), 1);

        // abort mid-sweep on ch0 20..25
        issue(1'b1, 1'b0, 2'd0, 5'd20, 5'd25, 16'd3);
        check("ab_lost_clr", 32'(rdy_lost), 0);
        repeat (6) tick();
        check("ab_dwell", 32'(sample_en), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_se", 32'(sample_en), 0);
        check("ab_ready", 32'(cfg_ready), 1);
        check("ab_tap", 32'(tapv(0)), 20);
        watch(20, 1'b0);
        check("ab_done", 32'(m_done), 0);
        check("ab_ld", 32'(m_ld), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
